// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 4-digit seven-segment scan driver: segment
// patterns, digit count, BCD type and the leading-zero blanking helper.
package seg7_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Blank mask per digit: a digit is blanked only if every more-significant
    // digit is blanked too; digit 0 is never blanked so zero still shows "0".
    function automatic logic [3:0] lz_blank_mask(
        input logic enable,
        input bcd_t d3,
        input bcd_t d2,
        input bcd_t d1
    );
        logic [3:0] mask;
        mask[3] = enable && (d3 == 4'd0);
        mask[2] = mask[3] && (d2 == 4'd0);
        mask[1] = mask[2] && (d1 == 4'd0);
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// BCD-to-seven-segment decoder (active-high), with blank override and a dash
// for the non-decimal codes 10..15.
module seg7_decode
    import seg7_scan_driver_pkg::*;
(
    input  bcd_t       code,
    input  logic       blank,
    output logic [6:0] pattern
);

    // Pattern lookup; blank wins over any code
    always_comb begin
        pattern = SEG_BLANK;
        if (blank) begin
            pattern = SEG_BLANK;
        end else begin
            case (code)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with frame-synchronous double
// buffering, optional leading-zero blanking and selectable output polarity.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dp_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       idx_r;
    logic             tick_s;
    logic             boundary_s;

    bcd_t             in_dig_s      [NUM_DIGITS];
    bcd_t             pending_dig_r [NUM_DIGITS];
    bcd_t             active_dig_r  [NUM_DIGITS];
    logic [3:0]       pending_dp_r;
    logic [3:0]       active_dp_r;
    logic             pending_valid_r;

    logic [3:0]       blank_mask_s;
    logic [3:0]       an_onehot_s;
    logic [6:0]       pattern_s;

    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic             frame_done_r;

    assign tick_s     = (cnt_r == CNT_MAX);
    assign boundary_s = tick_s && (idx_r == 2'd3);

    // Gather the digit ports into an indexable array
    always_comb begin
        in_dig_s[0] = dig0;
        in_dig_s[1] = dig1;
        in_dig_s[2] = dig2;
        in_dig_s[3] = dig3;
    end

    // Prescaler and scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (tick_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Double buffer: loads land in pending, promoted to active only at a frame
    // boundary; a load coinciding with the boundary bypasses straight to active
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pending_dig_r[i] <= 4'd0;
                active_dig_r[i]  <= 4'd0;
            end
            pending_dp_r    <= 4'b0000;
            active_dp_r     <= 4'b0000;
            pending_valid_r <= 1'b0;
        end else if (load && boundary_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_dig_r[i] <= in_dig_s[i];
            end
            active_dp_r     <= dp_in;
            pending_valid_r <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pending_dig_r[i] <= in_dig_s[i];
            end
            pending_dp_r    <= dp_in;
            pending_valid_r <= 1'b1;
        end else if (boundary_s && pending_valid_r) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_dig_r[i] <= pending_dig_r[i];
            end
            active_dp_r     <= pending_dp_r;
            pending_valid_r <= 1'b0;
        end else begin
            pending_valid_r <= pending_valid_r;
        end
    end

    // Blanking uses the displayed (active) digits and the live enable
    always_comb begin
        blank_mask_s = lz_blank_mask(blank_lz, active_dig_r[3],
                                     active_dig_r[2], active_dig_r[1]);
        an_onehot_s  = 4'b0001 << idx_r;
    end

    seg7_decode u_decode (
        .code    (active_dig_r[idx_r]),
        .blank   (blank_mask_s[idx_r]),
        .pattern (pattern_s)
    );

    // Output register: polarity applied here so the pins never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r         <= {4{ACTIVE_LOW}};
            seg_r        <= {7{ACTIVE_LOW}};
            dp_r         <= ACTIVE_LOW;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_onehot_s ^ {4{ACTIVE_LOW}};
            seg_r        <= pattern_s ^ {7{ACTIVE_LOW}};
            dp_r         <= active_dp_r[idx_r] ^ ACTIVE_LOW;
            frame_done_r <= boundary_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (REFRESH_DIV=4, active-low).
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dig0, dig1, dig2, dig3, dp_in;
    logic       load, blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_done;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int n          = 0;

    logic [6:0] exp_pat [4];
    logic [3:0] exp_dpm;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // Expected active-high patterns per digit, given most-significant first
    task automatic set_exp(input logic [6:0] p3, input logic [6:0] p2,
                           input logic [6:0] p1, input logic [6:0] p0, input logic [3:0] dpm);
        exp_pat[3] = p3; exp_pat[2] = p2; exp_pat[1] = p1; exp_pat[0] = p0;
        exp_dpm    = dpm;
    endtask

    task automatic put_load(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0, input logic [3:0] dpm);
        dig3 = d3; dig2 = d2; dig1 = d1; dig0 = d0; dp_in = dpm; load = 1'b1;
    endtask

    // Step m cycles; after cycle n the display shows digit ((n-1)/4)%4 and a
    // frame boundary registers frame_done on every 16th cycle
    task automatic step_check(input int m);
        for (int k = 0; k < m; k++) begin
            int d;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            @(posedge clk); #1;
            n++;
            d     = ((n - 1) / 4) % 4;
            e_an  = ~(4'b0001 << d);
            e_seg = ~exp_pat[d];
            check_val("an", an, e_an);
            check_val("seg", seg, e_seg);
            check_val("dp", dp, !exp_dpm[d]);
            check_val("frame_done", frame_done, (n % 16) == 0);
        end
    endtask

    task automatic check_blank(input string tag);
        check_val({tag, "_an"}, an, 4'hF);
        check_val({tag, "_seg"}, seg, 7'h7F);
        check_val({tag, "_dp"}, dp, 1'b1);
        check_val({tag, "_fd"}, frame_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; blank_lz = 1'b0;
        dig0 = 4'd0; dig1 = 4'd0; dig2 = 4'd0; dig3 = 4'd0; dp_in = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_blank("reset");
        rst = 1'b0;
        n   = 0;

        // Idle scan of zeros, two frames
        set_exp(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        step_check(32);

        // Mid-frame load of 1,2,3,4 only shows after the boundary
        step_check(4);
        put_load(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
        step_check(1);
        load = 1'b0;
        step_check(11);
        set_exp(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0000);
        step_check(16);

        // Leading-zero blanking: 0,0,7,0 then all zeros
        put_load(4'd0, 4'd0, 4'd7, 4'd0, 4'b0000);
        step_check(1);
        load = 1'b0; blank_lz = 1'b1;
        step_check(15);
        set_exp(7'h00, 7'h00, 7'h07, 7'h3F, 4'b0000);
        step_check(16);
        put_load(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        step_check(1);
        load = 1'b0;
        step_check(15);
        set_exp(7'h00, 7'h00, 7'h00, 7'h3F, 4'b0000);
        step_check(16);

        // Invalid code dash with decimal point on digit 1
        blank_lz = 1'b0;
        set_exp(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        put_load(4'd0, 4'd0, 4'd12, 4'd5, 4'b0010);
        step_check(1);
        load = 1'b0;
        step_check(15);
        set_exp(7'h3F, 7'h3F, 7'h40, 7'h6D, 4'b0010);
        step_check(16);
        // Blanking stops at the invalid code and leaves dp alone
        blank_lz = 1'b1;
        set_exp(7'h00, 7'h00, 7'h40, 7'h6D, 4'b0010);
        step_check(16);

        // Load on the boundary tick takes effect in the very next frame
        blank_lz = 1'b0;
        set_exp(7'h3F, 7'h3F, 7'h40, 7'h6D, 4'b0010);
        step_check(15);
        put_load(4'd0, 4'd0, 4'd0, 4'd9, 4'b0000);
        step_check(1);
        load = 1'b0;
        set_exp(7'h3F, 7'h3F, 7'h3F, 7'h6F, 4'b0000);
        step_check(16);

        // Two loads in one frame: the second one wins
        step_check(3);
        put_load(4'd1, 4'd1, 4'd1, 4'd1, 4'b1111);
        step_check(1);
        put_load(4'd2, 4'd3, 4'd6, 4'd8, 4'b0000);
        step_check(1);
        load = 1'b0;
        step_check(11);
        set_exp(7'h5B, 7'h4F, 7'h7D, 7'h7F, 4'b0000);
        step_check(16);

        // Reset mid-frame discards an outstanding pending load
        step_check(5);
        put_load(4'd8, 4'd8, 4'd8, 4'd8, 4'b1111);
        step_check(1);
        load = 1'b0;
        step_check(2);
        rst = 1'b1;
        @(posedge clk); #1;
        check_blank("midreset");
        rst = 1'b0;
        n   = 0;
        set_exp(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        step_check(32);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
